// File: rtl/fpu_32_pkg.sv
// Shared definitions for the single-precision divider operand path:
// IEEE-754 field positions, the canonical quiet NaN, the operand class
// enumeration, the per-entry record held by the operand FIFO, and small
// field helper functions.
package fpu_32_pkg;

    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;

    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [31:0] QNAN         = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_INF    = 2'd1,
        CLS_NAN    = 2'd2,
        CLS_FINITE = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        special;
        logic [31:0] special_result;
        logic        dz;
        logic        nv;
    } div_entry_t;

    // Subnormals are classified as finite nonzero; only an all-zero
    // exponent with an all-zero fraction counts as zero.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t cls;
        if (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) begin
            if (x[FRAC_MSB:0] != 23'd0) begin
                cls = CLS_NAN;
            end else begin
                cls = CLS_INF;
            end
        end else if ((x[EXP_MSB:EXP_LSB] == 8'd0) && (x[FRAC_MSB:0] == 23'd0)) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_FINITE;
        end
        return cls;
    endfunction

    // Replace a subnormal by a zero of the same sign; other values pass.
    function automatic logic [31:0] fp_flush_subnormal(input logic [31:0] x);
        logic [31:0] y;
        if ((x[EXP_MSB:EXP_LSB] == 8'd0) && (x[FRAC_MSB:0] != 23'd0)) begin
            y = {x[31], 31'd0};
        end else begin
            y = x;
        end
        return y;
    endfunction

endpackage

// File: rtl/fpu_32_div_classify.sv
// Combinational operand classification for the divider issue stage.
// Builds a complete FIFO entry (operands, bypass result, dz/nv flags)
// from a raw dividend/divisor pair.
// Optional build macro FPU_DIV_DENORM_FTZ_EN: when defined, subnormal
// operands are flushed to signed zero before classification and storage.
module fpu_32_div_classify
    import fpu_32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output div_entry_t  entry
);

    logic [31:0] a_s;
    logic [31:0] b_s;
    fp_class_t   cls_a_s;
    fp_class_t   cls_b_s;
    logic        sign_s;
    logic [31:0] inf_s;
    logic [31:0] zero_s;

`ifdef FPU_DIV_DENORM_FTZ_EN
    assign a_s = fp_flush_subnormal(a);
    assign b_s = fp_flush_subnormal(b);
`else
    assign a_s = a;
    assign b_s = b;
`endif

    assign cls_a_s = fp_classify(a_s);
    assign cls_b_s = fp_classify(b_s);
    assign sign_s  = a_s[31] ^ b_s[31];
    assign inf_s   = {sign_s, EXP_ALL_ONES, 23'd0};
    assign zero_s  = {sign_s, 31'd0};

    // Special-case priority: invalid, divide-by-zero, infinite quotient, zero quotient.
    always_comb begin
        entry                = '0;
        entry.a              = a_s;
        entry.b              = b_s;
        if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN) ||
            ((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_ZERO)) ||
            ((cls_a_s == CLS_INF) && (cls_b_s == CLS_INF))) begin
            entry.special        = 1'b1;
            entry.special_result = QNAN;
            entry.nv             = 1'b1;
        end else if ((cls_a_s == CLS_FINITE) && (cls_b_s == CLS_ZERO)) begin
            entry.special        = 1'b1;
            entry.special_result = inf_s;
            entry.dz             = 1'b1;
        end else if (cls_a_s == CLS_INF) begin
            // Divisor is finite or zero here; inf/0 is an exact infinity.
            entry.special        = 1'b1;
            entry.special_result = inf_s;
        end else if ((cls_a_s == CLS_ZERO) || (cls_b_s == CLS_INF)) begin
            entry.special        = 1'b1;
            entry.special_result = zero_s;
        end else begin
            entry.special        = 1'b0;
            entry.special_result = 32'd0;
        end
    end

endmodule

// File: rtl/fpu_32_div_operand_stage.sv
// Operand-issue stage in front of fpu_32_divider. Buffers classified A/B
// pairs in a small in-order FIFO and presents the head entry with its
// precomputed special-case result so the divider can be bypassed.
// in_ready is a register (no path from out_ready). Honours the optional
// build macro FPU_DIV_DENORM_FTZ_EN through fpu_32_div_classify.
module fpu_32_div_operand_stage
    import fpu_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           div_a,
    output logic [WIDTH-1:0]           div_b,
    output logic                       out_special,
    output logic [WIDTH-1:0]           out_special_result,
    output logic                       out_dz,
    output logic                       out_nv,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       flag_clr,
    output logic                       sticky_dz,
    output logic                       sticky_nv
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    div_entry_t        mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [LW-1:0]     level_nxt_s;
    logic              in_ready_r;
    logic              sticky_dz_r;
    logic              sticky_nv_r;
    logic              push_s;
    logic              pop_s;
    logic              empty_s;
    div_entry_t        cls_entry_s;
    div_entry_t        head_s;

    fpu_32_div_classify u_classify (
        .a     (in_a),
        .b     (in_b),
        .entry (cls_entry_s)
    );

    assign empty_s = (level_r == {LW{1'b0}});
    assign push_s  = in_valid & in_ready_r;
    assign pop_s   = (~empty_s) & out_ready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy and registered ready (ready follows next-cycle fullness).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= {LW{1'b0}};
            in_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r    <= level_nxt_s;
            in_ready_r <= (level_nxt_s != LVL_FULL);
        end
    end

    // Entry storage; contents are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= cls_entry_s;
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
        end
    end

    // Sticky exception flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_dz_r <= 1'b0;
            sticky_nv_r <= 1'b0;
        end else begin
            if (push_s && cls_entry_s.dz) begin
                sticky_dz_r <= 1'b1;
            end else if (flag_clr) begin
                sticky_dz_r <= 1'b0;
            end else begin
                sticky_dz_r <= sticky_dz_r;
            end
            if (push_s && cls_entry_s.nv) begin
                sticky_nv_r <= 1'b1;
            end else if (flag_clr) begin
                sticky_nv_r <= 1'b0;
            end else begin
                sticky_nv_r <= sticky_nv_r;
            end
        end
    end

    // Head entry, forced to zero while the FIFO is empty.
    always_comb begin
        head_s = '0;
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign in_ready           = in_ready_r;
    assign out_valid          = ~empty_s;
    assign level              = level_r;
    assign div_a              = head_s.a;
    assign div_b              = head_s.b;
    assign out_special        = head_s.special;
    assign out_special_result = head_s.special_result;
    assign out_dz             = head_s.dz;
    assign out_nv             = head_s.nv;
    assign sticky_dz          = sticky_dz_r;
    assign sticky_nv          = sticky_nv_r;

endmodule

// File: tb/tb_fpu_32_div_operand_stage.sv
// Self-checking bench for fpu_32_div_operand_stage: reset behaviour,
// a table of classification vectors, directed handshake/flag sequences,
// asynchronous reset at full occupancy and a randomized run against a
// queue-based reference model.
module tb_fpu_32_div_operand_stage;

    localparam int DEPTH = 2;
`ifdef FPU_DIV_DENORM_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        out_special;
    logic [31:0] out_special_result;
    logic        out_dz;
    logic        out_nv;
    logic [1:0]  level;
    logic        flag_clr = 1'b0;
    logic        sticky_dz;
    logic        sticky_nv;

    fpu_32_div_operand_stage #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_a               (in_a),
        .in_b               (in_b),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .div_a              (div_a),
        .div_b              (div_b),
        .out_special        (out_special),
        .out_special_result (out_special_result),
        .out_dz             (out_dz),
        .out_nv             (out_nv),
        .level              (level),
        .flag_clr           (flag_clr),
        .sticky_dz          (sticky_dz),
        .sticky_nv          (sticky_nv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sp;
        logic [31:0] res;
        logic        dz;
        logic        nv;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ea;
        logic        sp;
        logic [31:0] res;
        logic        dz;
        logic        nv;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic live = 1'b0;
    logic m_dz = 1'b0;
    logic m_nv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Quotient special cases from IEEE-754 division semantics.
    function automatic exp_t ref_div(input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t r;
        logic [31:0] a;
        logic [31:0] b;
        logic an, ai, az, af, bn, bi, bz, s;
        a = a_in;
        b = b_in;
        if (FTZ && a[30:23] == 8'd0 && a[22:0] != 23'd0) a = {a[31], 31'd0};
        if (FTZ && b[30:23] == 8'd0 && b[22:0] != 23'd0) b = {b[31], 31'd0};
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        az = (a[30:0] == 31'd0);
        af = !an && !ai && !az;
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        bz = (b[30:0] == 31'd0);
        s  = a[31] ^ b[31];
        r  = '{a: a, b: b, sp: 1'b0, res: 32'd0, dz: 1'b0, nv: 1'b0};
        if (an || bn || (az && bz) || (ai && bi)) begin
            r.sp = 1'b1; r.res = 32'h7FC0_0000; r.nv = 1'b1;
        end else if (af && bz) begin
            r.sp = 1'b1; r.res = {s, 8'hFF, 23'd0}; r.dz = 1'b1;
        end else if (ai) begin
            r.sp = 1'b1; r.res = {s, 8'hFF, 23'd0};
        end else if (az || bi) begin
            r.sp = 1'b1; r.res = {s, 31'd0};
        end
        return r;
    endfunction

    task automatic check_all();
        exp_t h;
        h = '{a: 32'd0, b: 32'd0, sp: 1'b0, res: 32'd0, dz: 1'b0, nv: 1'b0};
        if (q.size() > 0) h = q[0];
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(live && (q.size() < DEPTH)));
        chk("div_a", div_a, h.a);
        chk("div_b", div_b, h.b);
        chk("out_special", 32'(out_special), 32'(h.sp));
        chk("special_result", out_special_result, h.res);
        chk("out_dz", 32'(out_dz), 32'(h.dz));
        chk("out_nv", 32'(out_nv), 32'(h.nv));
        chk("sticky_dz", 32'(sticky_dz), 32'(m_dz));
        chk("sticky_nv", 32'(sticky_nv), 32'(m_nv));
    endtask

    // One clock: drive inputs, advance the model with the handshake outcome, check.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic clr);
        logic do_push, do_pop, pdz, pnv;
        exp_t e;
        in_valid = v; in_a = a; in_b = b; out_ready = ordy; flag_clr = clr;
        do_push = v && live && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        e = ref_div(a, b);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        pdz = do_push && e.dz;
        pnv = do_push && e.nv;
        if (clr) begin
            m_dz = pdz; m_nv = pnv;
        end else begin
            m_dz = m_dz | pdz; m_nv = m_nv | pnv;
        end
        live = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        live = 1'b0;
        m_dz = 1'b0;
        m_nv = 1'b0;
    endtask

    vec_t        vecs[14];
    logic [31:0] pool[10];

    function automatic logic [31:0] pick();
        int k;
        k = $urandom_range(0, 9);
        if (k == 9) return $urandom();
        return pool[k];
    endfunction

    initial begin
        vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1, 32'h7F80_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'hC000_0000, 32'h0000_0000, 32'hC000_0000, 1'b1, 32'hFF80_0000, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b1};
        vecs[6]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b1};
        vecs[7]  = '{32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b1};
        vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'h7F80_0000, 32'h8000_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0};
        vecs[10] = '{32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0};
        vecs[12] = '{32'h0000_0001, 32'h4000_0000, FTZ ? 32'h0000_0000 : 32'h0000_0001,
                     FTZ, 32'h0000_0000, 1'b0, 1'b0};
        vecs[13] = '{32'h0000_0001, 32'h0000_0000, FTZ ? 32'h0000_0000 : 32'h0000_0001,
                     1'b1, FTZ ? 32'h7FC0_0000 : 32'h7F80_0000, !FTZ, FTZ};

        pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000; pool[2] = 32'h7F80_0000;
        pool[3] = 32'hFF80_0000; pool[4] = 32'h7FC0_0000; pool[5] = 32'h7F80_0001;
        pool[6] = 32'h0000_0001; pool[7] = 32'h3F80_0000; pool[8] = 32'hC040_0000;
        pool[9] = 32'h0000_0000;

        // 1: reset held for three cycles.
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_div_a", div_a, 32'd0);
            chk("rst_level", 32'(level), 32'd0);
        end
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 2: fill with two normal pairs, then drain in order.
        cycle(1'b1, 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h3F80_0000, 32'h3F00_0000, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_a", div_a, 32'h4080_0000);
        chk("full_head_special", 32'(out_special), 32'd0);
        cycle(1'b1, 32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0);
        chk("pop1_head_a", div_a, 32'h3F80_0000);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drained_level", 32'(level), 32'd0);

        // Table of classification vectors, one at a time through an empty FIFO.
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            chk($sformatf("vec%0d_div_a", i), div_a, vecs[i].ea);
            chk($sformatf("vec%0d_div_b", i), div_b, vecs[i].b);
            chk($sformatf("vec%0d_special", i), 32'(out_special), 32'(vecs[i].sp));
            chk($sformatf("vec%0d_result", i), out_special_result, vecs[i].res);
            chk($sformatf("vec%0d_dz", i), 32'(out_dz), 32'(vecs[i].dz));
            chk($sformatf("vec%0d_nv", i), 32'(out_nv), 32'(vecs[i].nv));
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        end

        // 3: divide-by-zero of both signs.
        cycle(1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'hC000_0000, 32'h0000_0000, 1'b0, 1'b0);
        chk("dz_head_result", out_special_result, 32'h7F80_0000);
        chk("dz_head_flag", 32'(out_dz), 32'd1);
        chk("dz_sticky", 32'(sticky_dz), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("dz_second_result", out_special_result, 32'hFF80_0000);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // 4: 0/0 then 0/2.
        cycle(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0000, 32'h4000_0000, 1'b0, 1'b0);
        chk("nv_result", out_special_result, 32'h7FC0_0000);
        chk("nv_flag", 32'(out_nv), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("zero_q_special", 32'(out_special), 32'd1);
        chk("zero_q_nv", 32'(out_nv), 32'd0);
        chk("zero_q_result", out_special_result, 32'h0000_0000);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // 5: simultaneous push/pop at level 1, then flag_clr against a dz push.
        cycle(1'b1, 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h3F80_0000, 32'h3F00_0000, 1'b1, 1'b0);
        chk("pushpop_level", 32'(level), 32'd1);
        chk("pushpop_head_a", div_a, 32'h3F80_0000);
        cycle(1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
        chk("clr_vs_set_sticky", 32'(sticky_dz), 32'd1);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("clr_alone_sticky", 32'(sticky_dz), 32'd0);

        // 6: asynchronous reset at full occupancy.
        chk("pre_rst_level", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0001, 32'h4000_0000, 1'b0, 1'b0);
        chk("denorm_result", out_special_result, 32'h0000_0000);
        chk("denorm_special", 32'(out_special), 32'(FTZ));
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), pick(), pick(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_32_div_operand_stage.md
Name: fpu_32_div_operand_stage

Overview:
Registered operand-issue stage directly upstream of fpu_32_divider. Accepts A/B operand pairs over a valid/ready handshake and buffers them in a small FIFO. Classifies IEEE-754 single-precision special cases at enqueue. Presents the head entry to the divider's A/B inputs, plus a precomputed special-case result and exception flags, so downstream logic can bypass the divider for zero/inf/NaN operands.

Parameters:
WIDTH, 32, operand width; only 32 is supported.
DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous assert, active-low
in_valid  input  1  operand pair offered
in_ready  output  1  stage can accept; equals !full, forced 0 while rst_n is low
in_a  input  WIDTH  dividend
in_b  input  WIDTH  divisor
out_valid  output  1  head entry valid (!empty)
out_ready  input  1  consumer takes head entry
div_a  output  WIDTH  head dividend, wired to divider A
div_b  output  WIDTH  head divisor, wired to divider B
out_special  output  1  head result is decided by special case; divider output to be ignored
out_special_result  output  WIDTH  special-case result for head
out_dz  output  1  head is a divide-by-zero
out_nv  output  1  head is an invalid operation
level  output  $clog2(DEPTH+1)  current occupancy
flag_clr  input  1  clears sticky flags
sticky_dz  output  1  sticky divide-by-zero
sticky_nv  output  1  sticky invalid

Behaviour:
- Reset (async, rst_n=0): level=0, pointers=0, sticky_dz=sticky_nv=0, out_valid=0, in_ready=0. All data outputs read 0.
- Push: occurs when in_valid & in_ready at the rising clk edge. Pop: occurs when out_valid & out_ready.
- No combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
- Latency: a push into an empty FIFO shows out_valid=1 on the next cycle. Entries are in-order; pointers wrap modulo DEPTH.
- Simultaneous push and pop (0 < level < DEPTH): level is unchanged.
- When empty: div_a, div_b, out_special, out_special_result, out_dz and out_nv all read 0.
- Classification is computed combinationally from in_a/in_b and stored per entry. sign = a[31]^b[31]. NaN = exp==FF with frac!=0; inf = exp==FF with frac==0; zero = exp==0 with frac==0.
- Special-case rules, evaluated in this order:
  - Either operand NaN, 0/0, or inf/inf -> result 7FC00000, nv=1.
  - finite-nonzero/0 -> {sign,FF,0}, dz=1.
  - inf/finite -> {sign,FF,0}.
  - 0/nonzero or finite/inf -> {sign,31'b0}.
  - All other cases -> out_special=0, out_special_result=0.
- Sticky flags: set on push of an entry with dz/nv. Cleared by flag_clr. When a set and flag_clr occur in the same cycle, the set wins.
- Reset mid-operation: FIFO contents are discarded immediately and out_valid drops asynchronously.

Optional Feature:
FPU_DIV_DENORM_FTZ_EN
- Defined: a subnormal in_a/in_b (exp==0, frac!=0) is replaced by signed zero before classification and storage. div_a/div_b then carry the flushed value, and subnormal/x obeys the zero rules.
- Undefined: subnormals are stored unchanged and classified as finite nonzero.

Decomposition:
- Package fpu_32_pkg holds:
  - field constants EXP_MSB, EXP_LSB, FRAC_MSB and EXP_ALL_ONES;
  - QNAN = 32'h7FC00000;
  - typedef fp_class_t {zero, inf, nan, finite};
  - typedef div_entry_t {a, b, special, special_result, dz, nv}.
- One sub-module, fpu_32_div_classify: combinational operand classification plus special-result generation (including the FTZ option). The FIFO stays in the top.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> during reset in_ready=0, out_valid=0, div_a=0, level=0; after release in_ready=1.
2. out_ready=0; push 40800000/40000000, then 3F800000/3F000000 -> level=2, in_ready=0, head div_a=40800000, out_special=0. Then out_ready=1 -> pops in order, level reaches 0.
3. Push 40000000/00000000, then C0000000/00000000 -> special_result 7F800000 then FF800000, out_dz=1, sticky_dz=1.
4. Push 00000000/00000000, then 00000000/40000000 -> 7FC00000 with nv=1, then 00000000 with special=1 and nv=0.
5. At level=1, push and pop in the same cycle -> level stays 1, order preserved. Assert flag_clr in the same cycle as a dz push -> sticky_dz remains 1. flag_clr alone -> sticky_dz=0.
6. At level=2, drop rst_n mid-cycle -> out_valid=0 asynchronously, level=0. With FTZ_EN defined, push 00000001/40000000 -> special_result 00000000.
